apu_sample_channel: RTL and testbench
=====================================

Name: apu_sample_channel

Overview:
Parametrised successor to the single APU playback channel. It holds one voice's playback configuration. On each sample tick it fetches the mono or interleaved-stereo sample(s) at the current position from sample memory over a req/ack port. It scales them by volume, presents a left/right output pair, and advances the position with loop or one-shot termination. One instance per voice; the APU mixer sums the outputs of N instances.

Parameters:
ADDR_W, 32, sample-memory address width (addresses in sample-word units)
POS_W, 24, width of position, sample count and loop points
SAMPLE_W, 16, signed sample width
VOL_W, 8, unsigned volume width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cfg_start  in  1  pulse: latch all cfg_* inputs, position:=0, begin playing
cfg_stop  in  1  pulse: stop playback
cfg_base  in  ADDR_W  sample data base address
cfg_sample_count  in  POS_W  frames in sample
cfg_loop_start  in  POS_W  loop restart frame
cfg_loop_end  in  POS_W  loop wrap frame (exclusive)
cfg_loop_en  in  1  1 = loop, 0 = one-shot
cfg_mono  in  1  1 = mono, 0 = interleaved stereo L,R
cfg_volume_l  in  VOL_W  left volume (both sides when pan is compiled out)
cfg_volume_r  in  VOL_W  right volume
sample_tick  in  1  pulse: produce next output frame
mem_req  out  1  read request, held until mem_ack
mem_addr  out  ADDR_W  read address, stable while mem_req
mem_ack  in  1  read accepted; mem_rdata valid same cycle
mem_rdata  in  SAMPLE_W  sample word
out_valid  out  1  one-cycle pulse: new frame on out_left/out_right
out_left  out  SAMPLE_W  scaled left sample, held between pulses
out_right  out  SAMPLE_W  scaled right sample, held between pulses
playing  out  1  voice active
done  out  1  one-cycle pulse: one-shot reached end
underrun  out  1  sticky: tick arrived while busy; cleared by cfg_start

Behaviour:
- Interface: one clock, clk. Synchronous active-high reset, rst.
- Reset: all outputs are 0, state IDLE, position 0, config registers 0.
- States:
  - IDLE: waits for tick while playing.
  - FETCH_L: issues the left or mono read.
  - FETCH_R: issues the right read (stereo only).
  - EMIT: emits the frame and advances position.
  - DRAIN: waits for an outstanding ack after a stop.
- IDLE→FETCH_L on sample_tick && playing.
- Addresses: mono = base+pos; stereo left = base+2*pos; stereo right = base+2*pos+1. Computed in ADDR_W, wrapping modulo 2^ADDR_W.
- FETCH_L: mem_req=1 until mem_ack. Then → FETCH_R (stereo) or → EMIT (mono, right:=left).
- FETCH_R: same handshake, then → EMIT.
- EMIT, one cycle:
  - out_x = (sample_x * volume_x) >>> VOL_W, signed sample times zero-extended volume, arithmetic shift, truncated to SAMPLE_W.
  - out_valid=1.
  - Position advance: p1 = pos+1. If loop_en && p1==loop_end, pos:=loop_start. Else if p1==sample_count, one-shot end (with loop_en=1 this means loop_end was never reached; same behaviour). Otherwise pos:=p1.
  - One-shot end: playing:=0, done=1 in that cycle, pos unchanged.
  - Then → IDLE.
- Latency with zero-wait ack: tick at T gives out_valid at T+2 (mono) or T+3 (stereo).
- sample_tick outside IDLE: ignored, underrun:=1.
- cfg_stop: playing:=0 immediately.
  - With mem_req high and no ack that cycle: → DRAIN. DRAIN keeps mem_req/mem_addr until ack, discards data, → IDLE.
  - Otherwise → IDLE. No out_valid, no done.
- cfg_start: latches config, pos:=0, playing:=1, underrun:=0.
  - With a request outstanding: behaves as stop (DRAIN), and playing is re-asserted with the new config.
  - start and stop in the same cycle: start wins.
- Zero-length samples: cfg_sample_count=0 with loop_en=0 makes playing:=0 at start, with no fetch.
- Illegal loop config: loop_end ≤ loop_start, or loop_end > sample_count, is unchecked by hardware. The wrap rule above still applies literally.
- rst mid-handshake: mem_req drops immediately; the memory side must tolerate an abandoned request.

Optional Feature:
APU_CHANNEL_PAN_EN
- Defined: cfg_volume_l scales left and cfg_volume_r scales right, in mono and stereo.
- Undefined: cfg_volume_r is ignored; cfg_volume_l scales both sides; only one multiplier instance.

Decomposition:
- Package apu_pkg:
  - channel state enum (IDLE, FETCH_L, FETCH_R, EMIT, DRAIN).
  - packed struct apu_channel_cfg_t (base, counts, loop points, flags, volumes).
  - default parameter constants.
- Sub-module apu_volume_scaler: combinational signed×unsigned multiply and shift, parametrised SAMPLE_W/VOL_W. Instantiated once or twice depending on APU_CHANNEL_PAN_EN.

Test Plan:
- Mono one-shot: base=0x100, count=3, vol=255, zero-wait mem returning 0x4000,0x2000,0x7FFF; 4 ticks.
  - Reads at 0x100/0x101/0x102.
  - out_left=out_right=0x3FC0,0x1FE0,0x7F7F.
  - done on the 3rd EMIT; 4th tick does nothing.
- Stereo loop: count=4, loop_start=1, loop_end=3, loop_en=1; 6 ticks.
  - Position sequence 0,1,2,1,2,1.
  - Reads at base+{0,1},{2,3},{4,5},{2,3}.
  - playing stays 1.
- Negative and volume: mono sample 0x8000, vol=128 → out 0xC000. Sample 0xFFFF, vol=1 → out 0xFFFF (arithmetic shift).
- Backpressure/underrun: mem_ack delayed 5 cycles, second tick 2 cycles after first.
  - mem_addr stable throughout.
  - underrun=1.
  - Exactly one out_valid.
- Stop mid-fetch: cfg_stop while mem_req high, ack 3 cycles later.
  - mem_req held until ack, then 0.
  - No out_valid or done; playing=0 from the stop cycle.
- Pan: with APU_CHANNEL_PAN_EN, mono 0x4000, vol_l=255, vol_r=0 → L=0x3FC0, R=0. Without the macro → L=R=0x3FC0.

Source files
------------

// File: rtl/apu_pkg.sv
// apu_pkg: shared types and default sizes for the APU sample-playback channel.
//   chanState_t        channel sequencer states
//   apu_channel_cfg_t  one voice's playback configuration at the default widths
//   Apu*W              default parameter values for apu_sample_channel
package apu_pkg;

    localparam int unsigned ApuAddrW   = 32;
    localparam int unsigned ApuPosW    = 24;
    localparam int unsigned ApuSampleW = 16;
    localparam int unsigned ApuVolW    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StFetchL,
        StFetchR,
        StEmit,
        StDrain
    } chanState_t;

    typedef struct packed {
        logic [ApuAddrW-1:0] base;
        logic [ApuPosW-1:0]  sampleCount;
        logic [ApuPosW-1:0]  loopStart;
        logic [ApuPosW-1:0]  loopEnd;
        logic                loopEn;
        logic                mono;
        logic [ApuVolW-1:0]  volumeL;
        logic [ApuVolW-1:0]  volumeR;
    } apu_channel_cfg_t;

endpackage

// File: rtl/apu_volume_scaler.sv
// apu_volume_scaler: combinational volume scaling of one signed sample.
//   sample  in   signed sample word
//   volume  in   unsigned volume (0..2^VOL_W-1)
//   scaled  out  (sample * volume) >>> VOL_W, truncated to SAMPLE_W
module apu_volume_scaler #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned VOL_W    = 8
) (
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [VOL_W-1:0]    volume,
    output logic [SAMPLE_W-1:0] scaled
);

    localparam int unsigned ProdW = SAMPLE_W + VOL_W + 1;

    logic signed [ProdW-1:0] sampleExt;
    logic signed [ProdW-1:0] volumeExt;
    logic signed [ProdW-1:0] product;
    logic signed [ProdW-1:0] shifted;
    logic                    unusedShiftBits;

    // Volume is zero-extended so it stays non-negative in the signed product.
    assign sampleExt = {{(VOL_W + 1){sample[SAMPLE_W-1]}}, sample};
    assign volumeExt = {{(SAMPLE_W + 1){1'b0}}, volume};
    assign product   = sampleExt * volumeExt;
    assign shifted   = product >>> VOL_W;
    assign scaled    = shifted[SAMPLE_W-1:0];

    assign unusedShiftBits = ^shifted[ProdW-1:SAMPLE_W];

endmodule

// File: rtl/apu_sample_channel.sv
// apu_sample_channel: one APU voice. On each sample_tick while playing it reads the
// mono or interleaved-stereo frame at the current position over a req/ack port,
// scales it by volume, presents it on out_left/out_right and advances the position
// with loop wrap or one-shot end.
//   cfg_*        configuration, latched by cfg_start; cfg_stop halts playback
//   sample_tick  request for the next output frame
//   mem_*        sample-memory read port (req held until ack, rdata valid with ack)
//   out_*        scaled frame, out_valid pulses when it is new
//   playing/done/underrun  voice status
// Build option: APU_CHANNEL_PAN_EN gives independent left/right volume; without it
// cfg_volume_l scales both sides through a single time-shared multiplier.
module apu_sample_channel
    import apu_pkg::*;
#(
    parameter int unsigned ADDR_W   = ApuAddrW,
    parameter int unsigned POS_W    = ApuPosW,
    parameter int unsigned SAMPLE_W = ApuSampleW,
    parameter int unsigned VOL_W    = ApuVolW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_stop,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [POS_W-1:0]    cfg_sample_count,
    input  logic [POS_W-1:0]    cfg_loop_start,
    input  logic [POS_W-1:0]    cfg_loop_end,
    input  logic                cfg_loop_en,
    input  logic                cfg_mono,
    input  logic [VOL_W-1:0]    cfg_volume_l,
    input  logic [VOL_W-1:0]    cfg_volume_r,
    input  logic                sample_tick,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [SAMPLE_W-1:0] mem_rdata,
    output logic                out_valid,
    output logic [SAMPLE_W-1:0] out_left,
    output logic [SAMPLE_W-1:0] out_right,
    output logic                playing,
    output logic                done,
    output logic                underrun
);

    // Same layout as apu_channel_cfg_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [POS_W-1:0]  sampleCount;
        logic [POS_W-1:0]  loopStart;
        logic [POS_W-1:0]  loopEnd;
        logic              loopEn;
        logic              mono;
        logic [VOL_W-1:0]  volumeL;
        logic [VOL_W-1:0]  volumeR;
    } chanCfg_t;

    chanState_t          stateQ, stateD;
    chanCfg_t            cfgQ, cfgD, newCfg;
    logic [POS_W-1:0]    posQ, posD, posInc;
    logic                playingQ, playingD;
    logic                underrunQ, underrunD;
    logic [ADDR_W-1:0]   addrQ, addrD, posAddr, addrL, addrR;
    logic [SAMPLE_W-1:0] fetchLQ, fetchLD, fetchRQ, fetchRD;
    logic [SAMPLE_W-1:0] outLeftQ, outLeftD, outRightQ, outRightD;
    logic [SAMPLE_W-1:0] scaledL, scaledR;
    logic                reqOutstanding, emitValid, emitDone;

    // Samples are scaled as they arrive, so the held frame is already volume-applied.
`ifdef APU_CHANNEL_PAN_EN
    apu_volume_scaler #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W)) uScaleL (
        .sample (mem_rdata),
        .volume (cfgQ.volumeL),
        .scaled (scaledL)
    );
    apu_volume_scaler #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W)) uScaleR (
        .sample (mem_rdata),
        .volume (cfgQ.volumeR),
        .scaled (scaledR)
    );
`else
    logic unusedVolR;
    apu_volume_scaler #(.SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W)) uScale (
        .sample (mem_rdata),
        .volume (cfgQ.volumeL),
        .scaled (scaledL)
    );
    assign scaledR    = scaledL;
    assign unusedVolR = ^cfgQ.volumeR;
`endif

    always_comb begin
        newCfg.base        = cfg_base;
        newCfg.sampleCount = cfg_sample_count;
        newCfg.loopStart   = cfg_loop_start;
        newCfg.loopEnd     = cfg_loop_end;
        newCfg.loopEn      = cfg_loop_en;
        newCfg.mono        = cfg_mono;
        newCfg.volumeL     = cfg_volume_l;
        newCfg.volumeR     = cfg_volume_r;

        stateD    = stateQ;
        cfgD      = cfgQ;
        posD      = posQ;
        playingD  = playingQ;
        underrunD = underrunQ;
        addrD     = addrQ;
        fetchLD   = fetchLQ;
        fetchRD   = fetchRQ;
        outLeftD  = outLeftQ;
        outRightD = outRightQ;
        emitValid = 1'b0;
        emitDone  = 1'b0;

        posInc  = posQ + POS_W'(1);
        posAddr = ADDR_W'(posQ);
        addrL   = cfgQ.mono ? cfgQ.base + posAddr : cfgQ.base + (posAddr << 1);
        addrR   = cfgQ.base + (posAddr << 1) + ADDR_W'(1);

        // A request the memory has not taken yet must be carried to its ack.
        reqOutstanding = (stateQ == StFetchL || stateQ == StFetchR || stateQ == StDrain)
                         && !mem_ack;

        if (cfg_start || cfg_stop) begin
            stateD = reqOutstanding ? StDrain : StIdle;
            if (cfg_start) begin
                cfgD      = newCfg;
                posD      = '0;
                playingD  = !(cfg_sample_count == '0 && !cfg_loop_en);
                underrunD = 1'b0;
            end else begin
                playingD = 1'b0;
            end
        end else begin
            if (sample_tick && stateQ != StIdle) begin
                underrunD = 1'b1;
            end
            unique case (stateQ)
                StIdle: begin
                    if (sample_tick && playingQ) begin
                        stateD = StFetchL;
                        addrD  = addrL;
                    end
                end
                StFetchL: begin
                    if (mem_ack) begin
                        fetchLD = scaledL;
                        if (cfgQ.mono) begin
                            fetchRD = scaledR;
                            stateD  = StEmit;
                        end else begin
                            addrD  = addrR;
                            stateD = StFetchR;
                        end
                    end
                end
                StFetchR: begin
                    if (mem_ack) begin
                        fetchRD = scaledR;
                        stateD  = StEmit;
                    end
                end
                StEmit: begin
                    emitValid = 1'b1;
                    outLeftD  = fetchLQ;
                    outRightD = fetchRQ;
                    if (cfgQ.loopEn && posInc == cfgQ.loopEnd) begin
                        posD = cfgQ.loopStart;
                    end else if (posInc == cfgQ.sampleCount) begin
                        playingD = 1'b0;
                        emitDone = 1'b1;
                    end else begin
                        posD = posInc;
                    end
                    stateD = StIdle;
                end
                StDrain: begin
                    if (mem_ack) begin
                        stateD = StIdle;
                    end
                end
                default: stateD = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= StIdle;
            cfgQ      <= '0;
            posQ      <= '0;
            playingQ  <= 1'b0;
            underrunQ <= 1'b0;
            addrQ     <= '0;
            fetchLQ   <= '0;
            fetchRQ   <= '0;
            outLeftQ  <= '0;
            outRightQ <= '0;
        end else begin
            stateQ    <= stateD;
            cfgQ      <= cfgD;
            posQ      <= posD;
            playingQ  <= playingD;
            underrunQ <= underrunD;
            addrQ     <= addrD;
            fetchLQ   <= fetchLD;
            fetchRQ   <= fetchRD;
            outLeftQ  <= outLeftD;
            outRightQ <= outRightD;
        end
    end

    assign mem_req   = (stateQ == StFetchL || stateQ == StFetchR || stateQ == StDrain);
    assign mem_addr  = addrQ;
    assign out_valid = emitValid;
    assign out_left  = emitValid ? fetchLQ : outLeftQ;
    assign out_right = emitValid ? fetchRQ : outRightQ;
    assign playing   = playingQ;
    assign done      = emitDone;
    assign underrun  = underrunQ;

endmodule

// File: tb/tb_apu_sample_channel.sv
module tb_apu_sample_channel;
    import apu_pkg::*;

    localparam int NoOut = 99;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0;
    logic [31:0] cfg_base = '0;
    logic [23:0] cfg_sample_count = '0, cfg_loop_start = '0, cfg_loop_end = '0;
    logic        cfg_loop_en = 1'b0, cfg_mono = 1'b0;
    logic [7:0]  cfg_volume_l = '0, cfg_volume_r = '0;
    logic        sample_tick = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        out_valid;
    logic [15:0] out_left, out_right;
    logic        playing, done, underrun;

    apu_sample_channel dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_base(cfg_base), .cfg_sample_count(cfg_sample_count),
        .cfg_loop_start(cfg_loop_start), .cfg_loop_end(cfg_loop_end),
        .cfg_loop_en(cfg_loop_en), .cfg_mono(cfg_mono),
        .cfg_volume_l(cfg_volume_l), .cfg_volume_r(cfg_volume_r),
        .sample_tick(sample_tick), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .out_valid(out_valid),
        .out_left(out_left), .out_right(out_right), .playing(playing),
        .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        d;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] addrQ[$];
    logic [15:0] memArr[logic [31:0]];
    int          checks = 0;
    int          errors = 0;
    int          outCount = 0;
    int          ackDelay = 0;
    int          waitCnt = 0;
    logic        stallPrev = 1'b0;
    logic [31:0] prevAddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ack after ackDelay stalled cycles; verifies address order and stability.
    always @(negedge clk) begin
        if (mem_req) begin
            if (stallPrev) check("addr_stable", mem_addr, prevAddr);
            if (waitCnt >= ackDelay) begin
                mem_ack   <= 1'b1;
                mem_rdata <= memArr.exists(mem_addr) ? memArr[mem_addr] : 16'h0;
                waitCnt   <= 0;
                stallPrev <= 1'b0;
                if (addrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_unexpected: got addr %h expected no read", mem_addr);
                end else begin
                    check("read_addr", mem_addr, addrQ.pop_front());
                end
            end else begin
                mem_ack   <= 1'b0;
                waitCnt   <= waitCnt + 1;
                stallPrev <= 1'b1;
                prevAddr  <= mem_addr;
            end
        end else begin
            mem_ack   <= 1'b0;
            waitCnt   <= 0;
            stallPrev <= 1'b0;
        end
    end

    // Output monitor: pops the scoreboard on every out_valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                outCount <= outCount + 1;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got %h/%h expected no frame",
                             out_left, out_right);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    check("out_left", {16'h0, out_left}, {16'h0, e.l});
                    check("out_right", {16'h0, out_right}, {16'h0, e.r});
                    check("out_done", {31'h0, done}, {31'h0, e.d});
                end
            end else if (done) begin
                checks++;
                errors++;
                $display("FAIL done_without_valid: got done=1 expected 0");
            end
        end
    end

    function automatic apu_channel_cfg_t mkCfg(input logic [31:0] base, input int cnt,
                                               input int ls, input int le, input logic lp,
                                               input logic mono, input logic [7:0] vl,
                                               input logic [7:0] vr);
        apu_channel_cfg_t c;
        c.base = base;
        c.sampleCount = 24'(cnt);
        c.loopStart = 24'(ls);
        c.loopEnd = 24'(le);
        c.loopEn = lp;
        c.mono = mono;
        c.volumeL = vl;
        c.volumeR = vr;
        return c;
    endfunction

    task automatic startCfg(input apu_channel_cfg_t c);
        @(posedge clk); #1;
        cfg_base = c.base;
        cfg_sample_count = c.sampleCount;
        cfg_loop_start = c.loopStart;
        cfg_loop_end = c.loopEnd;
        cfg_loop_en = c.loopEn;
        cfg_mono = c.mono;
        cfg_volume_l = c.volumeL;
        cfg_volume_r = c.volumeR;
        cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    // Pulses sample_tick and returns the cycles until out_valid (NoOut if none).
    task automatic tickLat(output int lat);
        lat = NoOut;
        @(posedge clk); #1 sample_tick = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (n == 1) sample_tick = 1'b0;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    function automatic exp_t mkExp(input logic [15:0] l, input logic [15:0] r, input logic d);
        exp_t e;
        e.l = l;
        e.r = r;
        e.d = d;
        return e;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        int ackSeen;
        int posSeq[6] = '{0, 1, 2, 1, 2, 1};
        logic [15:0] stL[3], stR[3];

        memArr[32'h100] = 16'h4000; memArr[32'h101] = 16'h2000; memArr[32'h102] = 16'h7FFF;
        memArr[32'h200] = 16'h4000; memArr[32'h201] = 16'h2000;
        memArr[32'h202] = 16'h7FFF; memArr[32'h203] = 16'h8000;
        memArr[32'h204] = 16'h2000; memArr[32'h205] = 16'h4000;
        memArr[32'h300] = 16'h8000; memArr[32'h301] = 16'hFFFF;
        memArr[32'h400] = 16'h4000; memArr[32'h500] = 16'h1234;
        memArr[32'h700] = 16'h4000;
`ifdef APU_CHANNEL_PAN_EN
        stL = '{16'h3FC0, 16'h7F7F, 16'h1FE0};
        stR = '{16'h1000, 16'hC000, 16'h2000};
`else
        stL = '{16'h3FC0, 16'h7F7F, 16'h1FE0};
        stR = '{16'h1FE0, 16'h8080, 16'h3FC0};
`endif

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_left", {16'h0, out_left}, 32'h0);
        check("rst_playing", {31'h0, playing}, 32'h0);
        check("rst_underrun", {31'h0, underrun}, 32'h0);
        rst = 1'b0;

        // Mono one-shot, three frames then a dead tick
        startCfg(mkCfg(32'h100, 3, 0, 0, 1'b0, 1'b1, 8'd255, 8'd255));
        check("mono_playing", {31'h0, playing}, 32'h1);
        addrQ.push_back(32'h100); expQ.push_back(mkExp(16'h3FC0, 16'h3FC0, 1'b0));
        addrQ.push_back(32'h101); expQ.push_back(mkExp(16'h1FE0, 16'h1FE0, 1'b0));
        addrQ.push_back(32'h102); expQ.push_back(mkExp(16'h7F7F, 16'h7F7F, 1'b1));
        tickLat(lat);
        check("mono_latency", 32'(lat), 32'd2);
        tickLat(lat);
        tickLat(lat);
        check("mono_third_lat", 32'(lat), 32'd2);
        @(posedge clk); #1;
        check("mono_end_playing", {31'h0, playing}, 32'h0);
        tickLat(lat);
        check("mono_dead_tick", 32'(lat), NoOut);
        check("mono_held_left", {16'h0, out_left}, 32'h7F7F);

        // Stereo loop over frames 1..2
        startCfg(mkCfg(32'h200, 4, 1, 3, 1'b1, 1'b0, 8'd255, 8'd128));
        for (int i = 0; i < 6; i++) begin
            addrQ.push_back(32'h200 + 32'(2 * posSeq[i]));
            addrQ.push_back(32'h201 + 32'(2 * posSeq[i]));
            expQ.push_back(mkExp(stL[posSeq[i]], stR[posSeq[i]], 1'b0));
        end
        for (int i = 0; i < 6; i++) begin
            tickLat(lat);
            if (i == 0) check("stereo_latency", 32'(lat), 32'd3);
        end
        @(posedge clk); #1;
        check("stereo_playing", {31'h0, playing}, 32'h1);

        // Negative sample and small volume
        startCfg(mkCfg(32'h300, 1, 0, 0, 1'b0, 1'b1, 8'd128, 8'd128));
        addrQ.push_back(32'h300); expQ.push_back(mkExp(16'hC000, 16'hC000, 1'b1));
        tickLat(lat);
        startCfg(mkCfg(32'h301, 1, 0, 0, 1'b0, 1'b1, 8'd1, 8'd1));
        addrQ.push_back(32'h301); expQ.push_back(mkExp(16'hFFFF, 16'hFFFF, 1'b1));
        tickLat(lat);
        check("neg_latency", 32'(lat), 32'd2);

        // Backpressure with a second tick while busy
        ackDelay = 5;
        startCfg(mkCfg(32'h400, 8, 0, 0, 1'b0, 1'b1, 8'd255, 8'd255));
        check("bp_underrun_clear", {31'h0, underrun}, 32'h0);
        addrQ.push_back(32'h400); expQ.push_back(mkExp(16'h3FC0, 16'h3FC0, 1'b0));
        base = outCount;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("bp_underrun", {31'h0, underrun}, 32'h1);
        check("bp_one_output", 32'(outCount - base), 32'd1);

        // Stop while a read is outstanding
        ackDelay = 4;
        startCfg(mkCfg(32'h500, 8, 0, 0, 1'b0, 1'b1, 8'd255, 8'd255));
        check("stop_underrun_clear", {31'h0, underrun}, 32'h0);
        addrQ.push_back(32'h500);
        base = outCount;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        check("stop_req_before", {31'h0, mem_req}, 32'h1);
        cfg_stop = 1'b1;
        @(posedge clk); #1 cfg_stop = 1'b0;
        check("stop_playing", {31'h0, playing}, 32'h0);
        check("stop_req_held", {31'h0, mem_req}, 32'h1);
        ackSeen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk); #1;
            if (mem_ack) begin
                ackSeen = 1;
                break;
            end
        end
        check("stop_ack_seen", 32'(ackSeen), 32'd1);
        @(posedge clk); #1;
        check("stop_req_dropped", {31'h0, mem_req}, 32'h0);
        repeat (4) @(posedge clk);
        #1;
        check("stop_no_output", 32'(outCount - base), 32'd0);
        check("stop_still_idle", {31'h0, playing}, 32'h0);

        // Pan
        ackDelay = 0;
        startCfg(mkCfg(32'h700, 1, 0, 0, 1'b0, 1'b1, 8'd255, 8'd0));
        addrQ.push_back(32'h700);
`ifdef APU_CHANNEL_PAN_EN
        expQ.push_back(mkExp(16'h3FC0, 16'h0000, 1'b1));
`else
        expQ.push_back(mkExp(16'h3FC0, 16'h3FC0, 1'b1));
`endif
        tickLat(lat);
        check("pan_latency", 32'(lat), 32'd2);

        // Zero-length one-shot never plays
        startCfg(mkCfg(32'h800, 0, 0, 0, 1'b0, 1'b1, 8'd255, 8'd255));
        check("zero_len_playing", {31'h0, playing}, 32'h0);
        tickLat(lat);
        check("zero_len_no_out", 32'(lat), NoOut);

        // Reset mid-handshake abandons the request
        ackDelay = 5;
        startCfg(mkCfg(32'h600, 4, 0, 0, 1'b0, 1'b1, 8'd255, 8'd255));
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        check("rstmid_req_before", {31'h0, mem_req}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_req", {31'h0, mem_req}, 32'h0);
        check("rstmid_playing", {31'h0, playing}, 32'h0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_req_after", {31'h0, mem_req}, 32'h0);

        check("exp_queue_empty", 32'(expQ.size()), 32'd0);
        check("addr_queue_empty", 32'(addrQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
